// File: rtl/ex_stage_pkg.sv
// Shared ISA/CPU definitions for the execute stage: data widths, ALU op codes,
// memory/control op codes, exception codes, and the EX/MEM register bundle.
package ex_stage_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int REG_ADDR_W  = 5;

    typedef enum logic [3:0] {
        ALU_OP_NOP  = 4'd0,
        ALU_OP_AND  = 4'd1,
        ALU_OP_OR   = 4'd2,
        ALU_OP_XOR  = 4'd3,
        ALU_OP_ADDS = 4'd4,
        ALU_OP_ADDU = 4'd5,
        ALU_OP_SUBS = 4'd6,
        ALU_OP_SUBU = 4'd7,
        ALU_OP_SHRL = 4'd8,
        ALU_OP_SHLL = 4'd9
    } alu_op_e;

    localparam logic [1:0] MEM_OP_NOP  = 2'd0;
    localparam logic [1:0] MEM_OP_LDW  = 2'd1;
    localparam logic [1:0] MEM_OP_STW  = 2'd2;

    localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
    localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
    localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'h0;
    localparam logic [2:0] ISA_EXP_EXT_INT    = 3'h1;
    localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'h2;
    localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'h3;
    localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'h4;
    localparam logic [2:0] ISA_EXP_TRAP       = 3'h5;
    localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'h6;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br_flag;
        logic [1:0]             mem_op;
        logic [WORD_DATA_W-1:0] mem_wr_data;
        logic [1:0]             ctrl_op;
        logic [REG_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        logic [2:0]             exp_code;
        logic [WORD_DATA_W-1:0] out;
    } ex_reg_t;

    // Bubble: an invalid slot with no memory, control or register side effects.
    localparam ex_reg_t EX_REG_BUBBLE = '{
        pc:          30'h0,
        en:          1'b0,
        br_flag:     1'b0,
        mem_op:      MEM_OP_NOP,
        mem_wr_data: 32'h0,
        ctrl_op:     CTRL_OP_NOP,
        dst_addr:    5'h0,
        gpr_we_:     1'b1,
        exp_code:    ISA_EXP_NO_EXP,
        out:         32'h0
    };

    function automatic logic adds_ovf(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    function automatic logic subs_ovf(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] d);
        return (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle plus EX/MEM outputs and the forwarding path of ex_stage.
// master drives the id_* side, slave is the execute stage.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [WORD_ADDR_W-1:0] id_pc;
    logic                   id_en;
    logic [3:0]             id_alu_op;
    logic [WORD_DATA_W-1:0] id_alu_in_0;
    logic [WORD_DATA_W-1:0] id_alu_in_1;
    logic                   id_br_flag;
    logic [1:0]             id_mem_op;
    logic [WORD_DATA_W-1:0] id_mem_wr_data;
    logic [1:0]             id_ctrl_op;
    logic [REG_ADDR_W-1:0]  id_dst_addr;
    logic                   id_gpr_we_;
    logic [2:0]             id_exp_code;

    logic [WORD_DATA_W-1:0] fwd_data;
    logic [WORD_ADDR_W-1:0] ex_pc;
    logic                   ex_en;
    logic                   ex_br_flag;
    logic [1:0]             ex_mem_op;
    logic [WORD_DATA_W-1:0] ex_mem_wr_data;
    logic [1:0]             ex_ctrl_op;
    logic [REG_ADDR_W-1:0]  ex_dst_addr;
    logic                   ex_gpr_we_;
    logic [2:0]             ex_exp_code;
    logic [WORD_DATA_W-1:0] ex_out;

    modport master (
        output id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
               id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_,
               id_exp_code,
        input  fwd_data, ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data,
               ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
    );

    modport slave (
        input  id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
               id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_,
               id_exp_code,
        output fwd_data, ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data,
               ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
    );

endinterface

// File: rtl/ex_alu.sv
// Combinational ALU of the execute stage with signed-overflow flag.
// Overflow is only reported when EX_OVERFLOW_EXP_EN is defined.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [3:0]             alu_op,
    input  logic [WORD_DATA_W-1:0] in_0,
    input  logic [WORD_DATA_W-1:0] in_1,
    output logic [WORD_DATA_W-1:0] alu_out,
    output logic                   ovf
);

    logic [WORD_DATA_W-1:0] sum_s;
    logic [WORD_DATA_W-1:0] diff_s;

    assign sum_s  = in_0 + in_1;
    assign diff_s = in_0 - in_1;

    // Result select; unassigned op codes produce zero.
    always_comb begin
        alu_out = 32'h0;
        case (alu_op)
            ALU_OP_NOP:  alu_out = in_0;
            ALU_OP_AND:  alu_out = in_0 & in_1;
            ALU_OP_OR:   alu_out = in_0 | in_1;
            ALU_OP_XOR:  alu_out = in_0 ^ in_1;
            ALU_OP_ADDS: alu_out = sum_s;
            ALU_OP_ADDU: alu_out = sum_s;
            ALU_OP_SUBS: alu_out = diff_s;
            ALU_OP_SUBU: alu_out = diff_s;
            ALU_OP_SHRL: alu_out = in_0 >> in_1[4:0];
            ALU_OP_SHLL: alu_out = in_0 << in_1[4:0];
            default:     alu_out = 32'h0;
        endcase
    end

`ifdef EX_OVERFLOW_EXP_EN
    // Signed overflow for the signed add/subtract ops only.
    always_comb begin
        ovf = 1'b0;
        case (alu_op)
            ALU_OP_ADDS: ovf = adds_ovf(in_0, in_1, sum_s);
            ALU_OP_SUBS: ovf = subs_ovf(in_0, in_1, diff_s);
            default:     ovf = 1'b0;
        endcase
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, forwarding of the raw result, and the EX/MEM pipeline
// register (reset > stall > flush > load). Optional macro: EX_OVERFLOW_EXP_EN.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    ex_stage_if.slave  bus
);

    logic [WORD_DATA_W-1:0] alu_out_s;
    logic                   alu_ovf_s;
    ex_reg_t                load_s;
    ex_reg_t                ex_reg_d;
    ex_reg_t                ex_reg_q;

    ex_alu u_alu (
        .alu_op  (bus.id_alu_op),
        .in_0    (bus.id_alu_in_0),
        .in_1    (bus.id_alu_in_1),
        .alu_out (alu_out_s),
        .ovf     (alu_ovf_s)
    );

    assign bus.fwd_data = alu_out_s;

    // Incoming instruction as it would enter EX/MEM; an overflowing instruction
    // loses its store and writeback, but an earlier exception is kept as is.
    always_comb begin
        load_s.pc          = bus.id_pc;
        load_s.en          = bus.id_en;
        load_s.br_flag     = bus.id_br_flag;
        load_s.mem_wr_data = bus.id_mem_wr_data;
        load_s.ctrl_op     = bus.id_ctrl_op;
        load_s.dst_addr    = bus.id_dst_addr;
        load_s.out         = alu_out_s;
        if (alu_ovf_s && (bus.id_exp_code == ISA_EXP_NO_EXP)) begin
            load_s.exp_code = ISA_EXP_OVERFLOW;
            load_s.mem_op   = MEM_OP_NOP;
            load_s.gpr_we_  = 1'b1;
        end else begin
            load_s.exp_code = bus.id_exp_code;
            load_s.mem_op   = bus.id_mem_op;
            load_s.gpr_we_  = bus.id_gpr_we_;
        end
    end

    // Next register value; stall beats flush.
    always_comb begin
        if (stall) begin
            ex_reg_d = ex_reg_q;
        end else if (flush) begin
            ex_reg_d = EX_REG_BUBBLE;
        end else begin
            ex_reg_d = load_s;
        end
    end

    // EX/MEM pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_reg_q <= EX_REG_BUBBLE;
        end else begin
            ex_reg_q <= ex_reg_d;
        end
    end

    assign bus.ex_pc          = ex_reg_q.pc;
    assign bus.ex_en          = ex_reg_q.en;
    assign bus.ex_br_flag     = ex_reg_q.br_flag;
    assign bus.ex_mem_op      = ex_reg_q.mem_op;
    assign bus.ex_mem_wr_data = ex_reg_q.mem_wr_data;
    assign bus.ex_ctrl_op     = ex_reg_q.ctrl_op;
    assign bus.ex_dst_addr    = ex_reg_q.dst_addr;
    assign bus.ex_gpr_we_     = ex_reg_q.gpr_we_;
    assign bus.ex_exp_code    = ex_reg_q.exp_code;
    assign bus.ex_out         = ex_reg_q.out;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed test-plan cases then random traffic
// checked against an arithmetic reference model of the execute stage.
module tb_ex_stage;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic flush;

    ex_stage_if bus ();

    ex_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  mem_op;
        logic [31:0] wr_data;
        logic [1:0]  ctrl_op;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exc;
        logic [31:0] out;
    } exp_t;

    exp_t m;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic ovf_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t bubble();
        exp_t b;
        b.pc = 30'h0; b.en = 1'b0; b.br = 1'b0; b.mem_op = 2'd0; b.wr_data = 32'h0;
        b.ctrl_op = 2'd0; b.dst = 5'h0; b.we_ = 1'b1; b.exc = 3'h0; b.out = 32'h0;
        return b;
    endfunction

    // Reference ALU: returns the result and whether signed overflow occurred.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output logic ov);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        ov = 1'b0;
        case (op)
            4'd0: return a;
            4'd1: return a & b;
            4'd2: return a | b;
            4'd3: return a ^ b;
            4'd4: begin r = sa + sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                        return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000); end
            4'd5: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd6: begin r = sa - sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                        return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000); end
            4'd7: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            4'd8: return 32'(64'(a) / (64'd1 << b[4:0]));
            4'd9: return 32'((64'(a) * (64'd1 << b[4:0])) % 64'h1_0000_0000);
            default: return 32'h0;
        endcase
    endfunction

    // Check fwd_data, advance the model by one edge, queue expectation, clock.
    task automatic cycle();
        logic        ov;
        logic [31:0] r;
        exp_t        ld;
        #1;
        r = ref_alu(bus.id_alu_op, bus.id_alu_in_0, bus.id_alu_in_1, ov);
        chk("fwd_data", bus.fwd_data, r);
        ld.pc = bus.id_pc; ld.en = bus.id_en; ld.br = bus.id_br_flag;
        ld.wr_data = bus.id_mem_wr_data; ld.ctrl_op = bus.id_ctrl_op;
        ld.dst = bus.id_dst_addr; ld.out = r;
        ld.mem_op = bus.id_mem_op; ld.we_ = bus.id_gpr_we_; ld.exc = bus.id_exp_code;
        if (ovf_en && ov && bus.id_exp_code == 3'h0) begin
            ld.exc = 3'h3; ld.mem_op = 2'd0; ld.we_ = 1'b1;
        end
        if (reset)      m = bubble();
        else if (stall) m = m;
        else if (flush) m = bubble();
        else            m = ld;
        exp_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.id_pc          = 30'($urandom);
        bus.id_en          = 1'b1;
        bus.id_alu_op      = op;
        bus.id_alu_in_0    = a;
        bus.id_alu_in_1    = b;
        bus.id_br_flag     = 1'($urandom);
        bus.id_mem_op      = 2'($urandom_range(1, 3));
        bus.id_mem_wr_data = $urandom;
        bus.id_ctrl_op     = 2'($urandom);
        bus.id_dst_addr    = 5'($urandom_range(1, 31));
        bus.id_gpr_we_     = 1'b0;
        bus.id_exp_code    = 3'h0;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // Monitor: registered outputs are presented every cycle; compare vs queue head.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ex_pc",          32'(bus.ex_pc),          32'(mon_e.pc));
            chk("ex_en",          32'(bus.ex_en),          32'(mon_e.en));
            chk("ex_br_flag",     32'(bus.ex_br_flag),     32'(mon_e.br));
            chk("ex_mem_op",      32'(bus.ex_mem_op),      32'(mon_e.mem_op));
            chk("ex_mem_wr_data", bus.ex_mem_wr_data,      mon_e.wr_data);
            chk("ex_ctrl_op",     32'(bus.ex_ctrl_op),     32'(mon_e.ctrl_op));
            chk("ex_dst_addr",    32'(bus.ex_dst_addr),    32'(mon_e.dst));
            chk("ex_gpr_we_",     32'(bus.ex_gpr_we_),     32'(mon_e.we_));
            chk("ex_exp_code",    32'(bus.ex_exp_code),    32'(mon_e.exc));
            chk("ex_out",         bus.ex_out,              mon_e.out);
        end
    end

    initial begin
`ifdef EX_OVERFLOW_EXP_EN
        ovf_en = 1'b1;
`else
        ovf_en = 1'b0;
`endif
        m = bubble();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(4'd5, 32'h1234, 32'h1);
        cycle(); cycle();
        chk("reset_ex_out", bus.ex_out, 32'h0);
        chk("reset_gpr_we_", 32'(bus.ex_gpr_we_), 32'h1);
        reset = 1'b0;

        set_in(4'd5, 32'hFFFF_FFFF, 32'h1);
        #1; chk("addu_wrap_fwd", bus.fwd_data, 32'h0);
        cycle();
        chk("addu_wrap_out", bus.ex_out, 32'h0);
        chk("addu_wrap_exc", 32'(bus.ex_exp_code), 32'h0);
        chk("addu_wrap_we_", 32'(bus.ex_gpr_we_), 32'h0);

        set_in(4'd4, 32'h7FFF_FFFF, 32'h1);
        cycle();
        chk("adds_ovf_out", bus.ex_out, 32'h8000_0000);
        chk("adds_ovf_exc", 32'(bus.ex_exp_code), ovf_en ? 32'h3 : 32'h0);
        chk("adds_ovf_we_", 32'(bus.ex_gpr_we_), ovf_en ? 32'h1 : 32'h0);

        set_in(4'd9, 32'h1, 32'h25);
        cycle();
        chk("shll_out", bus.ex_out, 32'h20);
        set_in(4'd8, 32'h8000_0000, 32'd31);
        cycle();
        chk("shrl_out", bus.ex_out, 32'h1);

        set_in(4'd5, 32'd2, 32'd3);
        cycle();
        chk("load5_out", bus.ex_out, 32'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(4'd3, $urandom, $urandom);
            cycle();
            chk("stall_hold_out", bus.ex_out, 32'd5);
        end
        stall = 1'b0; flush = 1'b1;
        set_in(4'd2, 32'hF0, 32'h0F);
        cycle();
        chk("flush_en", 32'(bus.ex_en), 32'h0);
        chk("flush_out", bus.ex_out, 32'h0);
        flush = 1'b0;
        set_in(4'd1, 32'hFF00, 32'h0FF0);
        cycle();
        stall = 1'b1; flush = 1'b1;
        set_in(4'd0, 32'hDEAD, 32'h0);
        cycle();
        chk("stall_flush_hold", bus.ex_out, 32'h0F00);
        flush = 1'b0; reset = 1'b1;
        cycle();
        chk("reset_in_stall_out", bus.ex_out, 32'h0);
        chk("reset_in_stall_we_", 32'(bus.ex_gpr_we_), 32'h1);
        stall = 1'b0;
        set_in(4'd5, 32'd7, 32'd8);
        cycle();
        chk("reset_held_en", 32'(bus.ex_en), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 5) == 0);
            set_in(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
            bus.id_en       = 1'($urandom);
            bus.id_gpr_we_  = 1'($urandom);
            bus.id_mem_op   = 2'($urandom);
            bus.id_exp_code = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'h0;
            cycle();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
